sr_ff_bank: RTL and testbench



---
 rtl/sr_ff_bank.sv | 145 ++++++++++++++
 tb/tb_sr_ff_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : sr_ff_bank
//  Purpose  : Clocked multi-channel SR storage bank. Each channel has an input
//             glitch filter, configurable resolution of the forbidden S=R=1
//             pair, and a sticky invalid flag. A shared saturating counter
//             counts the forbidden-pair entries.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             en       - update enable for q, invalid and err_cnt
//             s, r     - per-channel set/reset requests (polarity: ACTIVE_LOW)
//             clr_err  - synchronous clear of invalid and err_cnt
//             q, qb    - stored state and its inverse
//             changed  - one-cycle pulse after an edge where q[i] toggled
//             invalid  - sticky per-channel forbidden-pair flag
//             err_cnt  - saturating count of forbidden-pair entries
//  Revision : 1.0 - initial release
// ============================================================================
module sr_ff_bank #(
    parameter int CH         = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int FILTER     = 2,
    parameter int PRIORITY   = 0,
    parameter int RESET_VAL  = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CH-1:0]    s,
    input  logic [CH-1:0]    r,
    input  logic             clr_err,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    qb,
    output logic [CH-1:0]    changed,
    output logic [CH-1:0]    invalid,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam int EW = $clog2(CH + 1);
    localparam int SW = CNT_W + EW;

    localparam logic [FW-1:0]    c_fmax    = FW'(FILTER);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic             c_rst_bit = (RESET_VAL != 0);

    logic [CH-1:0]          r_cand_set;
    logic [CH-1:0]          r_cand_rst;
    logic [CH-1:0][FW-1:0]  r_fcnt;
    logic [CH-1:0]          r_prev_forb;

    logic [CH-1:0]          w_set;
    logic [CH-1:0]          w_rst;
    logic [CH-1:0][FW-1:0]  w_fcnt_nxt;
    logic [CH-1:0]          w_qual;
    logic [CH-1:0]          w_forb;
    logic [CH-1:0]          w_entry;
    logic [CH-1:0]          w_q_nxt;
    logic [EW-1:0]          w_entry_cnt;
    logic [SW-1:0]          w_sum;
    logic [CNT_W-1:0]       w_cnt_nxt;

    always_comb begin
        w_set       = (ACTIVE_LOW != 0) ? ~s : s;
        w_rst       = (ACTIVE_LOW != 0) ? ~r : r;
        w_fcnt_nxt  = '0;
        w_qual      = '0;
        w_forb      = '0;
        w_entry     = '0;
        w_q_nxt     = q;
        w_entry_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            // The count is evaluated on its post-edge value, so a pair first
            // seen at edge k qualifies at edge k+FILTER (FILTER+1 samples).
            if ((w_set[i] != r_cand_set[i]) || (w_rst[i] != r_cand_rst[i]))
                w_fcnt_nxt[i] = '0;
            else if (r_fcnt[i] == c_fmax)
                w_fcnt_nxt[i] = r_fcnt[i];
            else
                w_fcnt_nxt[i] = r_fcnt[i] + 1'b1;

            w_qual[i] = (w_fcnt_nxt[i] == c_fmax);
            w_forb[i] = w_qual[i] & w_set[i] & w_rst[i];

            if (en && w_qual[i]) begin
                case ({w_set[i], w_rst[i]})
                    2'b10:   w_q_nxt[i] = 1'b1;
                    2'b01:   w_q_nxt[i] = 1'b0;
                    2'b11: begin
                        if (PRIORITY == 1)
                            w_q_nxt[i] = 1'b1;
                        else if (PRIORITY == 2)
                            w_q_nxt[i] = 1'b0;
                        else
                            w_q_nxt[i] = q[i];
                    end
                    default: w_q_nxt[i] = q[i];
                endcase
            end

            // An entry needs the previous edge not to have had a qualified
            // forbidden pair; that history runs regardless of en, so a pair
            // that qualified while disabled is never counted later.
            w_entry[i]  = en & w_forb[i] & ~r_prev_forb[i];
            w_entry_cnt = w_entry_cnt + EW'(w_entry[i]);
        end

        w_sum = (clr_err ? {SW{1'b0}} : SW'(err_cnt)) + SW'(w_entry_cnt);
        if (w_sum > SW'(c_cnt_max))
            w_cnt_nxt = c_cnt_max;
        else
            w_cnt_nxt = w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_set  <= '0;
            r_cand_rst  <= '0;
            r_fcnt      <= '0;
            r_prev_forb <= '0;
            q           <= {CH{c_rst_bit}};
            changed     <= '0;
            invalid     <= '0;
            err_cnt     <= '0;
        end else begin
            r_cand_set  <= w_set;
            r_cand_rst  <= w_rst;
            r_fcnt      <= w_fcnt_nxt;
            r_prev_forb <= w_forb;
            if (en) begin
                q       <= w_q_nxt;
                changed <= w_q_nxt ^ q;
                invalid <= clr_err ? w_entry : (invalid | w_entry);
                err_cnt <= w_cnt_nxt;
            end else begin
                changed <= '0;
            end
        end
    end

    assign qb = ~q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_ff_bank
//  Purpose  : Directed self-checking bench for sr_ff_bank. Four instances share
//             the stimulus: default build, PRIORITY=1, PRIORITY=2, CNT_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_ff_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr_err;

    logic [3:0] q_a, qb_a, ch_a, inv_a;
    logic [7:0] err_a;
    logic [3:0] q_b, qb_b, ch_b, inv_b;
    logic [7:0] err_b;
    logic [3:0] q_c, qb_c, ch_c, inv_c;
    logic [7:0] err_c;
    logic [3:0] q_d, qb_d, ch_d, inv_d;
    logic [1:0] err_d;

    int checks   = 0;
    int failures = 0;

    sr_ff_bank #(.CH(4), .ACTIVE_LOW(1), .FILTER(2), .PRIORITY(0), .RESET_VAL(0), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_a), .qb(qb_a), .changed(ch_a), .invalid(inv_a), .err_cnt(err_a));

    sr_ff_bank #(.CH(4), .ACTIVE_LOW(1), .FILTER(2), .PRIORITY(1), .RESET_VAL(0), .CNT_W(8)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_b), .qb(qb_b), .changed(ch_b), .invalid(inv_b), .err_cnt(err_b));

    sr_ff_bank #(.CH(4), .ACTIVE_LOW(1), .FILTER(2), .PRIORITY(2), .RESET_VAL(0), .CNT_W(8)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_c), .qb(qb_c), .changed(ch_c), .invalid(inv_c), .err_cnt(err_c));

    sr_ff_bank #(.CH(4), .ACTIVE_LOW(1), .FILTER(2), .PRIORITY(0), .RESET_VAL(0), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_d), .qb(qb_d), .changed(ch_d), .invalid(inv_d), .err_cnt(err_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr_err = 1'b0; s = 4'hF; r = 4'hF;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (q_a !== 4'h0)   begin failures++; $display("FAIL reset_q got=%h exp=0", q_a); end
        checks++; if (qb_a !== 4'hF)  begin failures++; $display("FAIL reset_qb got=%h exp=f", qb_a); end
        checks++; if (inv_a !== 4'h0) begin failures++; $display("FAIL reset_invalid got=%h exp=0", inv_a); end
        checks++; if (err_a !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_a); end
        checks++; if (ch_a !== 4'h0)  begin failures++; $display("FAIL reset_changed got=%h exp=0", ch_a); end
        tick(1);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_set_reset();
        s = 4'hE;
        tick(2);
        checks++; if (q_a !== 4'h0) begin failures++; $display("FAIL set_early got=%h exp=0", q_a); end
        tick(1);
        checks++; if (q_a !== 4'h1)  begin failures++; $display("FAIL set_q got=%h exp=1", q_a); end
        checks++; if (qb_a !== 4'hE) begin failures++; $display("FAIL set_qb got=%h exp=e", qb_a); end
        checks++; if (ch_a !== 4'h1) begin failures++; $display("FAIL set_changed got=%h exp=1", ch_a); end
        tick(1);
        checks++; if (ch_a !== 4'h0) begin failures++; $display("FAIL set_changed_clear got=%h exp=0", ch_a); end
        s = 4'hF; r = 4'hE;
        tick(2);
        checks++; if (q_a !== 4'h1) begin failures++; $display("FAIL rst_early got=%h exp=1", q_a); end
        tick(1);
        checks++; if (q_a !== 4'h0)  begin failures++; $display("FAIL rst_q got=%h exp=0", q_a); end
        checks++; if (ch_a !== 4'h1) begin failures++; $display("FAIL rst_changed got=%h exp=1", ch_a); end
        r = 4'hF;
        tick(3);
    endtask

    task automatic test_glitch();
        s = 4'hD;
        tick(2);
        s = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++; if (q_a !== 4'h0 || ch_a !== 4'h0) begin
                failures++; $display("FAIL glitch_q got q=%h chg=%h exp q=0 chg=0", q_a, ch_a);
            end
        end
        en = 1'b0;
        s = 4'hD;
        tick(4);
        checks++; if (q_a !== 4'h0) begin failures++; $display("FAIL en0_q got=%h exp=0", q_a); end
        s = 4'hF;
        tick(1);
        en = 1'b1;
        tick(3);
        checks++; if (q_a !== 4'h0) begin failures++; $display("FAIL en0_after got=%h exp=0", q_a); end
    endtask

    task automatic test_forbidden();
        s = 4'h3; r = 4'h3;
        tick(2);
        checks++; if (err_a !== 8'd0) begin failures++; $display("FAIL forb_early got=%0d exp=0", err_a); end
        tick(1);
        checks++; if (inv_a !== 4'hC) begin failures++; $display("FAIL forb_invalid got=%h exp=c", inv_a); end
        checks++; if (err_a !== 8'd2) begin failures++; $display("FAIL forb_err got=%0d exp=2", err_a); end
        tick(7);
        checks++; if (err_a !== 8'd2) begin failures++; $display("FAIL forb_hold_err got=%0d exp=2", err_a); end
        checks++; if (q_a !== 4'h0)   begin failures++; $display("FAIL forb_hold_q got=%h exp=0", q_a); end
        checks++; if (q_b !== 4'hC)   begin failures++; $display("FAIL forb_p1_q got=%h exp=c", q_b); end
        checks++; if (q_c !== 4'h0)   begin failures++; $display("FAIL forb_p2_q got=%h exp=0", q_c); end
        s = 4'h7; r = 4'h7;
        tick(3);
        s = 4'h3; r = 4'h3;
        tick(2);
        checks++; if (err_a !== 8'd2) begin failures++; $display("FAIL reent_early got=%0d exp=2", err_a); end
        tick(1);
        checks++; if (err_a !== 8'd3) begin failures++; $display("FAIL reent_err got=%0d exp=3", err_a); end
        checks++; if (inv_a !== 4'hC) begin failures++; $display("FAIL reent_invalid got=%h exp=c", inv_a); end
    endtask

    task automatic test_clr_err();
        s = 4'h2; r = 4'h2;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checks++; if (inv_a !== 4'h1) begin failures++; $display("FAIL clr_win_invalid got=%h exp=1", inv_a); end
        checks++; if (err_a !== 8'd1) begin failures++; $display("FAIL clr_win_err got=%0d exp=1", err_a); end
        tick(1);
        checks++; if (err_a !== 8'd1) begin failures++; $display("FAIL clr_hold_err got=%0d exp=1", err_a); end
        s = 4'hF; r = 4'hF;
        tick(3);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checks++; if (inv_a !== 4'h0 || err_a !== 8'd0) begin
            failures++; $display("FAIL clr_plain got inv=%h err=%0d exp inv=0 err=0", inv_a, err_a);
        end
    endtask

    task automatic test_en_freeze();
        en = 1'b0;
        s = 4'hE; r = 4'hE;
        tick(4);
        checks++; if (err_a !== 8'd0 || inv_a !== 4'h0) begin
            failures++; $display("FAIL en0_forb got inv=%h err=%0d exp inv=0 err=0", inv_a, err_a);
        end
        en = 1'b1;
        tick(2);
        checks++; if (err_a !== 8'd0) begin failures++; $display("FAIL en_rise_forb got=%0d exp=0", err_a); end
        s = 4'hF; r = 4'hF;
        tick(3);
    endtask

    task automatic test_saturate();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        s = 4'hF; r = 4'hF;
        tick(2);
        for (int n = 1; n <= 5; n++) begin
            s = 4'hE; r = 4'hE;
            tick(3);
            checks++; if (err_d !== ((n > 3) ? 2'd3 : 2'(n))) begin
                failures++; $display("FAIL sat_err2 entry=%0d got=%0d exp=%0d", n, err_d, (n > 3) ? 3 : n);
            end
            checks++; if (err_a !== 8'(n)) begin
                failures++; $display("FAIL sat_err8 entry=%0d got=%0d exp=%0d", n, err_a, n);
            end
            s = 4'hF; r = 4'hF;
            tick(3);
        end
    endtask

    task automatic test_reset_mid();
        s = 4'hE;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (q_a !== 4'h0 || err_a !== 8'd0) begin
            failures++; $display("FAIL midrst got q=%h err=%0d exp q=0 err=0", q_a, err_a);
        end
        #1 rst_n = 1'b1;
        tick(2);
        checks++; if (q_a !== 4'h0) begin failures++; $display("FAIL midrst_early got=%h exp=0", q_a); end
        tick(1);
        checks++; if (q_a !== 4'h1) begin failures++; $display("FAIL midrst_set got=%h exp=1", q_a); end
        s = 4'hF;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_glitch();
        test_forbidden();
        test_clr_err();
        test_en_freeze();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
